// File: rtl/seg_scan_decoder_if.sv
// Scanned 7-segment bus plus the decoded-frame outputs of seg_scan_decoder.
// master drives the scan lines and observes the frame; slave is the decoder.
interface seg_scan_decoder_if;
  logic [7:0]  i_seg;
  logic [3:0]  i_dig;
  logic [15:0] o_val;
  logic [3:0]  o_dp;
  logic [3:0]  o_blank;
  logic        o_frame;
  logic        o_valid;
  logic        o_err;

  modport master (
    output i_seg, i_dig,
    input  o_val, o_dp, o_blank, o_frame, o_valid, o_err
  );

  modport slave (
    input  i_seg, i_dig,
    output o_val, o_dp, o_blank, o_frame, o_valid, o_err
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// Decodes a multiplexed 4-digit 7-segment scan back into a 16-bit frame.
// Define SEG_DECODE_HEX_EN to also accept the hex glyphs A,b,C,d,E,F.
module seg_scan_decoder #(
  parameter int SETTLE         = 4,
  parameter int TIMEOUT        = 1000000,
  parameter int CNT_BITS       = 20,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input logic           i_clk,
  input logic           i_rst,
  seg_scan_decoder_if.slave bus
);

  localparam int SBITS = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CAPTURED} state_t;

  state_t              state, state_n;
  logic [SBITS-1:0]    cnt, cnt_n;
  logic [7:0]          seg_r, seg_p;
  logic [3:0]          dig_r, dig_p;
  logic [3:0]          sel, sel_prev;
  logic                multi_hot, same, capture;
  logic [3:0]          dec_nib;
  logic                dec_blank, dec_bad;
  logic [15:0]         shadow_val, val_q;
  logic [3:0]          shadow_dp, shadow_blank, mask, dp_q, blank_q;
  logic                frame_q, valid_q, err_q;
  logic [CNT_BITS-1:0] tcnt;

  // Multi-hot selects collapse to zero-hot so they never start a capture.
  function automatic logic [3:0] eff_sel(input logic [3:0] d);
    return ((d & (d - 4'd1)) == 4'd0) ? d : 4'd0;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      seg_r <= 8'h00;
      seg_p <= 8'h00;
      dig_r <= 4'h0;
      dig_p <= 4'h0;
    end else begin
      seg_r <= SEG_ACTIVE_LOW ? ~bus.i_seg : bus.i_seg;
      dig_r <= DIG_ACTIVE_LOW ? ~bus.i_dig : bus.i_dig;
      seg_p <= seg_r;
      dig_p <= dig_r;
    end
  end

  assign sel       = eff_sel(dig_r);
  assign sel_prev  = eff_sel(dig_p);
  assign multi_hot = (dig_r != 4'd0) && (sel == 4'd0);
  assign same      = (sel == sel_prev) && (seg_r == seg_p);

  always_comb begin
    dec_nib   = 4'hF;
    dec_blank = 1'b0;
    dec_bad   = 1'b0;
    case (seg_r[6:0])
      7'h00: begin dec_nib = 4'h0; dec_blank = 1'b1; end
      7'h3F: dec_nib = 4'h0;
      7'h06: dec_nib = 4'h1;
      7'h5B: dec_nib = 4'h2;
      7'h4F: dec_nib = 4'h3;
      7'h66: dec_nib = 4'h4;
      7'h6D: dec_nib = 4'h5;
      7'h7D: dec_nib = 4'h6;
      7'h07, 7'h27: dec_nib = 4'h7;
      7'h7F: dec_nib = 4'h8;
      7'h6F, 7'h67: dec_nib = 4'h9;
`ifdef SEG_DECODE_HEX_EN
      7'h77: dec_nib = 4'hA;
      7'h7C: dec_nib = 4'hB;
      7'h39: dec_nib = 4'hC;
      7'h5E: dec_nib = 4'hD;
      7'h79: dec_nib = 4'hE;
      7'h71: dec_nib = 4'hF;
`endif
      default: dec_bad = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // A new one-hot value (from any state) restarts the dwell; with SETTLE<=1 it captures at once.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    capture = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sel != 4'd0) begin
          if (SETTLE <= 1) begin capture = 1'b1; state_n = ST_CAPTURED; end
          else begin state_n = ST_SETTLE; cnt_n = SBITS'(1); end
        end
      end
      ST_SETTLE: begin
        if (sel == 4'd0) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else if (!same) begin
          if (SETTLE <= 1) begin capture = 1'b1; state_n = ST_CAPTURED; end
          else cnt_n = SBITS'(1);
        end else if (int'(cnt) + 1 >= SETTLE) begin
          capture = 1'b1;
          state_n = ST_CAPTURED;
        end else begin
          cnt_n = cnt + SBITS'(1);
        end
      end
      ST_CAPTURED: begin
        if (sel != sel_prev) begin
          if (sel == 4'd0) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
          end else if (SETTLE <= 1) begin
            capture = 1'b1;
          end else begin
            state_n = ST_SETTLE;
            cnt_n   = SBITS'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Frame publish, shadow capture, timeout and the sticky error flag.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      shadow_val   <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '0;
      mask         <= '0;
      val_q        <= '0;
      dp_q         <= '0;
      blank_q      <= '0;
      frame_q      <= 1'b0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      tcnt         <= '0;
    end else begin
      frame_q <= 1'b0;
      if (capture) begin
        for (int k = 0; k < 4; k++) begin
          if (sel[k]) begin
            shadow_val[4*k +: 4] <= dec_nib;
            shadow_dp[k]         <= seg_r[7];
            shadow_blank[k]      <= dec_blank;
          end
        end
        if (dec_bad) err_q <= 1'b1;
      end
      if (multi_hot) err_q <= 1'b1;

      if (mask == 4'hF) begin
        val_q   <= shadow_val;
        dp_q    <= shadow_dp;
        blank_q <= shadow_blank;
        frame_q <= 1'b1;
        valid_q <= 1'b1;
        tcnt    <= '0;
        mask    <= capture ? sel : 4'd0;
      end else begin
        if (capture) mask <= mask | sel;
        if (tcnt < CNT_BITS'(TIMEOUT)) tcnt <= tcnt + CNT_BITS'(1);
        if (tcnt >= CNT_BITS'(TIMEOUT - 1)) valid_q <= 1'b0;
      end
    end
  end

  assign bus.o_val   = val_q;
  assign bus.o_dp    = dp_q;
  assign bus.o_blank = blank_q;
  assign bus.o_frame = frame_q;
  assign bus.o_valid = valid_q;
  assign bus.o_err   = err_q;

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
Receive-side counterpart of the multiplexed 4-digit 7-segment display driver.
- Samples the scanned segment/digit-select bus and decodes each digit's pattern back to a BCD/hex nibble.
- Publishes a complete 4-digit frame once every digit has been seen stable.
- Used for loopback self-check and bench scoreboarding of the display path, in the same clock domain as the driver.

Parameters:
SETTLE, 4, consecutive cycles a digit select + segment pattern must hold unchanged before capture (>=1).
TIMEOUT, 1000000, cycles without a completed frame before o_valid drops.
CNT_BITS, 20, width of the timeout counter; must hold TIMEOUT.
SEG_ACTIVE_LOW, 1, 1 = segment lines active-low (common anode); 0 = active-high.
DIG_ACTIVE_LOW, 1, 1 = digit selects active-low; 0 = active-high.

Ports:
i_clk  in  1  system clock, rising edge.
i_rst  in  1  asynchronous, active-low reset.
i_seg  in  8  scanned segments; bit7 = dp, bits6..0 = g,f,e,d,c,b,a.
i_dig  in  4  scanned digit selects; bit0 = ones digit … bit3 = thousands digit.
o_val  out 16 decoded frame; nibble k = digit k (o_val[3:0] = ones).
o_dp   out 4  decimal point per digit in the last frame.
o_blank out 4 digit k was blank (all segments off) in the last frame.
o_frame out 1 one-cycle pulse when o_val/o_dp/o_blank update.
o_valid out 1 high while frames are arriving within TIMEOUT.
o_err  out 1  sticky: an unrecognised pattern or a multi-hot select was seen.

Behaviour:
- Reset (i_rst=0, async): all outputs 0; capture mask, shadow registers, counters and state cleared. Release is synchronous to i_clk.
- Input stage: i_seg/i_dig registered once and normalised to active-high per the polarity parameters. All decisions use the registered copy, which adds 1 cycle of latency.
- Select classification:
  - Zero-hot: inter-digit blanking; not an error.
  - One-hot: active digit k.
  - Multi-hot: sets o_err and is treated as zero-hot.
- FSM states:
  - IDLE: no active digit. On one-hot select → SETTLE, stable counter = 1.
  - SETTLE: counter increments while select and segments are identical to the previous cycle. Any change restarts the counter with the new value (zero-hot → IDLE). When the counter reaches SETTLE → CAPTURED.
  - CAPTURED: decode the pattern into shadow nibble k, dp k and blank k; set mask bit k. Stay in CAPTURED, with no recapture, until the select changes, then re-evaluate as in IDLE. Capture happens exactly once per digit dwell.
- Decode (segments g..a, active-high view): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
  - 00 → nibble 0, blank=1.
  - Any other value → nibble F, o_err=1.
  - 7 also accepts 27; 9 also accepts 67.
- Frame completion: in the cycle the mask reaches 1111:
  - copy the shadows to o_val/o_dp/o_blank on the next edge and pulse o_frame for one cycle;
  - clear the mask, set o_valid, clear the timeout counter.
  - A recapture of a digit already in the mask overwrites its shadow; it does not complete a frame early.
- Timeout counter: increments every cycle and saturates. At TIMEOUT, o_valid drops; o_val holds its last value. The next frame sets o_valid again.
- o_err clears only on reset.
- Simultaneous events: a frame completion in the same cycle as a timeout → the frame wins (o_valid stays 1).

Optional Feature:
SEG_DECODE_HEX_EN
- Defined: additionally decodes A=77 b=7C C=39 d=5E E=79 F=71 to nibbles A..F without error. Pattern 71 then yields F with o_err unaffected.
- Undefined: these patterns decode to F and set o_err.

Test Plan:
- Scan digits 0..3 (active-low) with 1,2,3,4, each dwell 8 cycles with 2 blank cycles between, SETTLE=4 → o_frame pulses once per pass; o_val=16'h4321, o_blank=0, o_err=0, o_valid=1.
- Digit 0 pattern glitches for 1 cycle mid-dwell of 6 cycles (SETTLE=4) → no capture this pass; frame completes only on the next clean pass.
- i_dig=0011 (active-high view) for 10 cycles → o_err=1 and stays 1; no capture for either digit.
- Pattern 77 on digit 2 → without SEG_DECODE_HEX_EN: nibble 2 = F, o_err=1; with it: nibble 2 = A, o_err=0.
- Stop scanning for TIMEOUT=50 cycles (bench override) → o_valid falls at cycle 50; o_val holds its value. Resume scanning → o_valid rises with the next o_frame.
- Assert i_rst mid-dwell → all outputs 0 immediately (async). After release, the first o_frame arrives only after all 4 digits are recaptured.
